// File: rtl/sevenseg_scan_n.sv
// Multiplexed N-digit common-anode 7-segment driver with per-frame input snapshots,
// blink masking and leading-zero blanking. Define SEVSEG_DIM_EN to add PWM brightness.
`timescale 1ns/1ps
module sevenseg_scan_n #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic                          lz_blank,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0]                    brightness,
`endif
    output logic [NUM_DIGITS-1:0]         anodes,
    output logic [6:0]                    segs,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    live_q, live_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_mask_q, snap_mask_d;
    logic                    snap_lz_q, snap_lz_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic [6:0]              segs_q, segs_d;
    logic                    dp_q, dp_d;

    logic                    tick;
    logic                    frame_start;
    logic                    blink_wrap;
    logic                    dim_on;
    logic [3:0]              nib_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   nib_zero;
    logic [NUM_DIGITS-1:0]   lz_zero;
    logic                    lz_run;
    logic [3:0]              nib_sel;
    logic                    blank;

    function automatic logic [6:0] hex_to_segs(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Refresh prescaler, scan index and blink timebase.
    always_comb begin
        tick        = (presc_q == PRESC_W'(REFRESH_DIV - 1));
        presc_d     = tick ? '0 : presc_q + 1'b1;
        frame_start = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        idx_d       = idx_q;
        if (tick) begin
            idx_d = frame_start ? '0 : idx_q + 1'b1;
        end
        live_d        = live_q | tick;
        blink_wrap    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    end

    // Inputs are captured only at frame start so a whole frame shows one coherent value.
    always_comb begin
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_mask_d   = snap_mask_q;
        snap_lz_d     = snap_lz_q;
        if (frame_start) begin
            snap_digits_d = digits;
            snap_dp_d     = dp_in;
            snap_mask_d   = blink_mask;
            snap_lz_d     = lz_blank;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib_arr[gi]  = snap_digits_d[4*gi +: 4];
            assign nib_zero[gi] = (snap_digits_d[4*gi +: 4] == 4'h0);
        end
    endgenerate

    // lz_zero[k]: digit k and every digit above it are zero.
    always_comb begin
        lz_run  = 1'b1;
        lz_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_run     = lz_run & nib_zero[k];
            lz_zero[k] = lz_run;
        end
    end

`ifdef SEVSEG_DIM_EN
    logic [31:0] dim_thr;
    assign dim_thr = ((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) >> 4;
    assign dim_on  = (32'(presc_d) < dim_thr);
`else
    assign dim_on = 1'b1;
`endif

    // Outputs are computed from next-state values so they change on the same edge as the scan.
    always_comb begin
        nib_sel  = nib_arr[idx_d];
        blank    = ~live_d
                 | (~blink_phase_d & snap_mask_d[idx_d])
                 | (snap_lz_d & (idx_d != '0) & lz_zero[idx_d]);
        segs_d   = blank ? 7'h7F : hex_to_segs(nib_sel);
        dp_d     = blank ? 1'b1 : ~snap_dp_d[idx_d];
        anodes_d = '1;
        if (!blank && en && dim_on) begin
            anodes_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            idx_q         <= IDX_W'(NUM_DIGITS - 1);
            live_q        <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_mask_q   <= '0;
            snap_lz_q     <= 1'b0;
            anodes_q      <= '1;
            segs_q        <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            idx_q         <= idx_d;
            live_q        <= live_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_mask_q   <= snap_mask_d;
            snap_lz_q     <= snap_lz_d;
            anodes_q      <= anodes_d;
            segs_q        <= segs_d;
            dp_q          <= dp_d;
        end
    end

    assign anodes   = anodes_q;
    assign segs     = segs_q;
    assign dp       = dp_q;
    assign scan_idx = idx_q;

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Scoreboard bench for sevenseg_scan_n (4 digits, 4-clock slots, 32-clock blink half-period).
`timescale 1ns/1ps
module tb_sevenseg_scan_n;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BD = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        lz_blank;
`ifdef SEVSEG_DIM_EN
    logic [3:0]  brightness;
`endif
    logic [3:0]  anodes;
    logic [6:0]  segs;
    logic        dp;
    logic [1:0]  scan_idx;

    sevenseg_scan_n #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .lz_blank   (lz_blank),
`ifdef SEVSEG_DIM_EN
        .brightness (brightness),
`endif
        .anodes     (anodes),
        .segs       (segs),
        .dp         (dp),
        .scan_idx   (scan_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] an;
        logic [6:0] segs;
        logic       dp;
        bit         chk_segs;
        int         edge_n;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   e = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input int edge_n, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, edge_n, act, expv);
        end
    endtask

    // Monitor: each clock after an edge the DUT presents a new output word.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sbq.size() > 0) begin
                x = sbq.pop_front();
                check("scan_idx", x.edge_n, 32'(scan_idx), 32'(x.idx));
                check("anodes", x.edge_n, 32'(anodes), 32'(x.an));
                if (x.chk_segs) begin
                    check("segs", x.edge_n, 32'(segs), 32'(x.segs));
                    check("dp", x.edge_n, 32'(dp), 32'(x.dp));
                end
                $display("edge %0d idx %0d anodes %b segs %h dp %b", x.edge_n, scan_idx, anodes, segs, dp);
            end
        end
    end

    task automatic push_step(input logic [1:0] idx, input logic [3:0] an, input logic [6:0] sg,
                             input logic d, input bit cs);
        exp_t x;
        x.idx      = idx;
        x.an       = an;
        x.segs     = sg;
        x.dp       = d;
        x.chk_segs = cs;
        x.edge_n   = e + 1;
        sbq.push_back(x);
        @(negedge clk);
        e++;
    endtask

    // One full frame (16 edges). Expectations use the values applied at frame start;
    // mid_at/en_off (-1 = unused) inject a mid-frame digit change or a 6-clock enable drop.
    task automatic frame(input logic [15:0] dig, input logic [3:0] dpi, input logic [3:0] bm,
                         input logic lz, input int mid_at, input logic [15:0] dig_mid, input int en_off);
        logic [3:0] nib;
        logic [3:0] an;
        logic       bl;
        logic       lzb;
        digits     = dig;
        dp_in      = dpi;
        blink_mask = bm;
        lz_blank   = lz;
        for (int i = 0; i < 16; i++) begin
            int s;
            s = i / 4;
            if (i == mid_at) digits = dig_mid;
            en  = !(en_off >= 0 && i >= en_off && i < en_off + 6);
            nib = dig[4*s +: 4];
            lzb = 1'b0;
            if (lz && s >= 1) begin
                lzb = 1'b1;
                for (int k = s; k < 4; k++) if (dig[4*k +: 4] != 4'h0) lzb = 1'b0;
            end
            bl = lzb || (bm[s] && (((e + 1) / BD) % 2 == 1));
            an = 4'hF;
            if (!bl && en) an[s] = 1'b0;
            push_step(2'(s), an, bl ? 7'h7F : glyph[nib], bl ? 1'b1 : ~dpi[s], en);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        digits     = 16'h1234;
        dp_in      = 4'h0;
        blink_mask = 4'h0;
        lz_blank   = 1'b0;
`ifdef SEVSEG_DIM_EN
        brightness = 4'hF;
`endif
        repeat (3) @(negedge clk);
        check("reset_anodes", 0, 32'(anodes), 32'hF);
        check("reset_segs", 0, 32'(segs), 32'h7F);
        check("reset_dp", 0, 32'(dp), 32'h1);
        check("reset_scan_idx", 0, 32'(scan_idx), 32'h3);
        rst = 1'b0;
        e   = 0;

        repeat (3) push_step(2'd3, 4'hF, 7'h7F, 1'b1, 1'b1);
        frame(16'h1234, 4'h0, 4'h0, 1'b0, -1, 16'h0, -1);
        frame(16'h0007, 4'h0, 4'h0, 1'b1, -1, 16'h0, -1);
        frame(16'h0007, 4'h0, 4'h0, 1'b0, -1, 16'h0, -1);
        repeat (4) frame(16'h1234, 4'h0, 4'b0001, 1'b0, -1, 16'h0, -1);
        frame(16'h1234, 4'h0, 4'h0, 1'b0, 9, 16'h5678, -1);
        frame(16'h5678, 4'h0, 4'h0, 1'b0, -1, 16'h0, -1);
        frame(16'h5678, 4'b0101, 4'h0, 1'b0, -1, 16'h0, 2);
        frame(16'h0500, 4'h0, 4'h0, 1'b1, -1, 16'h0, -1);
        frame(16'hABCD, 4'h0, 4'h0, 1'b0, -1, 16'h0, -1);
        frame(16'hF96E, 4'b1000, 4'h0, 1'b0, -1, 16'h0, -1);

        #2 rst = 1'b1;
        #1;
        check("async_rst_anodes", e, 32'(anodes), 32'hF);
        check("async_rst_segs", e, 32'(segs), 32'h7F);
        check("async_rst_dp", e, 32'(dp), 32'h1);
        check("async_rst_scan_idx", e, 32'(scan_idx), 32'h3);
        check("queue_drained", e, 32'(sbq.size()), 32'h0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
